// File: rtl/busca_instrucao.sv
// -----------------------------------------------------------------------------
// busca_instrucao -- instruction fetch stage.
//
// Issues one fetch at a time to instruction memory, holds the returned word
// until decode accepts it, and handles redirects (flush + restart) including
// the case where a request is already in flight and its response must be
// dropped when it arrives.
//
// States:
//   BUSCA    : request outstanding at mem_addr (or about to be, right after reset)
//   CHEIO    : instruction held on instr/pc with instr_valid=1, no request
//   DESCARTE : in-flight response belongs to a flushed path; wait and drop it
//   ERRO     : terminal misaligned-redirect trap (only with MISALIGN_TRAP_EN)
//
// Optional feature macro: MISALIGN_TRAP_EN
//   Adds output erro_alinhamento and the ERRO state. A redirect whose target
//   has redirect_pc[1:0] != 0 sets the flag and parks the block until reset.
//
// Parameters:
//   RESET_PC          first fetch address after reset
// Ports:
//   clk               clock, rising-edge
//   reset             synchronous, active-high
//   mem_req/mem_addr  fetch request and its byte address
//   mem_ack/mem_rdata memory response (data valid only with ack)
//   instr/pc          held instruction word and its address
//   instr_valid       instr/pc hold an undelivered instruction
//   instr_ready       decode accepts instr this cycle
//   redirect/redirect_pc  flush and restart fetch at redirect_pc
//   n_instr           count of completed instr_valid & instr_ready transfers
//   erro_alinhamento  misaligned redirect trap flag (MISALIGN_TRAP_EN only)
// -----------------------------------------------------------------------------
module busca_instrucao #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [63:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [63:0] n_instr
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        erro_alinhamento
`endif
);

  typedef enum logic [1:0] {
    ST_BUSCA    = 2'd0,
    ST_CHEIO    = 2'd1,
    ST_DESCARTE = 2'd2
`ifdef MISALIGN_TRAP_EN
    ,
    ST_ERRO     = 2'd3
`endif
  } estado_t;

  // A fetch target is misaligned when its two low address bits are non-zero.
  function automatic logic desalinhado(input logic [63:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  estado_t     state_q, state_d;
  logic [63:0] pc_busca_q, pc_busca_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] pc_q, pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [63:0] n_instr_q, n_instr_d;
  logic        ack_s;
  logic        trap_s;

  // mem_req is registered, so the first cycle after reset sits in BUSCA with
  // no request yet; an ack in that cycle cannot belong to us and is ignored.
  assign ack_s = mem_ack & mem_req_q;

`ifdef MISALIGN_TRAP_EN
  logic erro_q, erro_d;
  assign trap_s = redirect & desalinhado(redirect_pc) & (state_q != ST_ERRO);
`else
  assign trap_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BUSCA;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect always takes priority over ack/ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BUSCA: begin
        if (redirect) begin
          // With a request in flight and no ack yet, its response must be dropped.
          if (mem_req_q && !mem_ack) begin
            state_d = ST_DESCARTE;
          end else begin
            state_d = ST_BUSCA;
          end
        end else if (ack_s) begin
          state_d = ST_CHEIO;
        end else begin
          state_d = ST_BUSCA;
        end
      end
      ST_CHEIO: begin
        if (redirect || instr_ready) begin
          state_d = ST_BUSCA;
        end else begin
          state_d = ST_CHEIO;
        end
      end
      ST_DESCARTE: begin
        if (mem_ack) begin
          state_d = ST_BUSCA;
        end else begin
          state_d = ST_DESCARTE;
        end
      end
`ifdef MISALIGN_TRAP_EN
      ST_ERRO: begin
        state_d = ST_ERRO;
      end
`endif
      default: begin
        state_d = ST_BUSCA;
      end
    endcase
`ifdef MISALIGN_TRAP_EN
    if (trap_s) begin
      state_d = ST_ERRO;
    end else begin
      state_d = state_d;
    end
`endif
  end

  // Output / datapath next values derived from current state and inputs.
  always_comb begin
    pc_busca_d = pc_busca_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    n_instr_d  = n_instr_q;
    case (state_q)
      ST_BUSCA: begin
        if (redirect) begin
          pc_busca_d = redirect_pc;
          // Old address stays on the bus until its ack if one is outstanding.
          if (mem_req_q && !mem_ack) begin
            mem_addr_d = mem_addr_q;
          end else begin
            mem_addr_d = redirect_pc;
          end
        end else if (ack_s) begin
          instr_d    = mem_rdata;
          pc_d       = mem_addr_q;
          pc_busca_d = mem_addr_q + 64'd4;
        end else begin
          mem_addr_d = pc_busca_q;
        end
      end
      ST_CHEIO: begin
        if (redirect) begin
          pc_busca_d = redirect_pc;
          mem_addr_d = redirect_pc;
        end else if (instr_ready) begin
          n_instr_d  = n_instr_q + 64'd1;
          mem_addr_d = pc_busca_q;
        end else begin
          mem_addr_d = mem_addr_q;
        end
      end
      ST_DESCARTE: begin
        // Last redirect wins, including one arriving with the stale ack.
        if (redirect) begin
          pc_busca_d = redirect_pc;
        end else begin
          pc_busca_d = pc_busca_q;
        end
        if (mem_ack) begin
          mem_addr_d = redirect ? redirect_pc : pc_busca_q;
        end else begin
          mem_addr_d = mem_addr_q;
        end
      end
      default: begin
        pc_busca_d = pc_busca_q;
        mem_addr_d = mem_addr_q;
      end
    endcase
    mem_req_d     = (state_d == ST_BUSCA) || (state_d == ST_DESCARTE);
    instr_valid_d = (state_d == ST_CHEIO);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_busca_q    <= RESET_PC;
      mem_addr_q    <= RESET_PC;
      mem_req_q     <= 1'b0;
      instr_q       <= 32'h0;
      pc_q          <= 64'h0;
      instr_valid_q <= 1'b0;
      n_instr_q     <= 64'h0;
    end else begin
      pc_busca_q    <= pc_busca_d;
      mem_addr_q    <= mem_addr_d;
      mem_req_q     <= mem_req_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      n_instr_q     <= n_instr_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Sticky trap flag, cleared only by reset.
  always_comb begin
    if (trap_s) begin
      erro_d = 1'b1;
    end else begin
      erro_d = erro_q;
    end
  end

  // Trap flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      erro_q <= 1'b0;
    end else begin
      erro_q <= erro_d;
    end
  end

  assign erro_alinhamento = erro_q;
`endif

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign n_instr     = n_instr_q;

endmodule
